// File: rtl/scene_sequencer.sv
// Scene sequencer: menu/game/result scene flow with blanked transitions.
// Every scene change passes through a frame-counted BLANK and a one-cycle SWITCH.
module scene_sequencer #(
  parameter int          BLANK_FRAMES   = 8,
  parameter int          RESULT_TIMEOUT = 600,
  parameter logic [4:0]  ESC_KEY        = 5'h1b
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [4:0] key_pulse,
  input  logic       menu_valid,
  input  logic [1:0] menu_sel,
  input  logic       game_done,
  input  logic       game_die,
  input  logic       choice_valid,
  input  logic [1:0] choice,
  output logic [3:0] scene,
  output logic       blank,
  output logic       game_restart,
  output logic [7:0] clear_count
);

  localparam logic [3:0] S_MENU   = 4'd0;
  localparam logic [3:0] S_B1     = 4'd1;
  localparam logic [3:0] S_B1_OK  = 4'd2;
  localparam logic [3:0] S_B1_DIE = 4'd3;
  localparam logic [3:0] S_B2     = 4'd4;
  localparam logic [3:0] S_B2_OK  = 4'd5;
  localparam logic [3:0] S_B2_DIE = 4'd6;
  localparam logic [3:0] S_SD     = 4'd7;
  localparam logic [3:0] S_SD_OK  = 4'd8;

  localparam logic [7:0]  BF_LOAD = 8'(BLANK_FRAMES);
  localparam logic [15:0] TO_LAST = 16'(RESULT_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BLANK  = 2'd1,
    SWITCH = 2'd2
  } phase_t;

  phase_t      phase_q, phase_d;
  logic [3:0]  scene_q, target_q;
  logic [7:0]  cnt_q, clear_q;
  logic [15:0] tcnt_q;

  logic        ev;
  logic [3:0]  ev_tgt;
  logic        is_res;
  logic        has_next;
  logic [3:0]  res_game;
  logic [3:0]  res_next;
  logic        timeout;
  logic        tgt_ok;
  logic        live_game;

  // Result-scene decode: which game a retry returns to, and what "next" means.
  always_comb begin
    is_res   = 1'b0;
    has_next = 1'b0;
    res_game = S_MENU;
    res_next = S_MENU;
    case (scene_q)
      S_B1_OK:  begin is_res = 1'b1; has_next = 1'b1;
                      res_game = S_B1; res_next = S_B2; end
      S_B2_OK:  begin is_res = 1'b1; has_next = 1'b1;
                      res_game = S_B2; res_next = S_SD; end
      S_SD_OK:  begin is_res = 1'b1; has_next = 1'b1;
                      res_game = S_SD; res_next = S_B1; end
      S_B1_DIE: begin is_res = 1'b1; res_game = S_B1; end
      S_B2_DIE: begin is_res = 1'b1; res_game = S_B2; end
      default:  ;
    endcase
  end

  assign timeout = frame_tick && (tcnt_q >= TO_LAST);

  always_comb begin
    ev     = 1'b0;
    ev_tgt = S_MENU;
    case (scene_q)
      S_MENU: begin
        if (menu_valid && menu_sel == 2'b00) begin
          ev = 1'b1; ev_tgt = S_SD;
        end else if (menu_valid && menu_sel == 2'b01) begin
          ev = 1'b1; ev_tgt = S_B1;
        end
      end
      S_B1, S_B2: begin
        if (game_done) begin
          ev = 1'b1; ev_tgt = scene_q + 4'd1;
        end else if (game_die) begin
          ev = 1'b1; ev_tgt = scene_q + 4'd2;
        end else if (key_pulse == ESC_KEY) begin
          ev = 1'b1; ev_tgt = scene_q;
        end
      end
      S_SD: begin
        if (game_done) begin
          ev = 1'b1; ev_tgt = S_SD_OK;
        end else if (key_pulse == ESC_KEY) begin
          ev = 1'b1; ev_tgt = S_SD;
        end
      end
      S_B1_OK, S_B2_OK, S_SD_OK, S_B1_DIE, S_B2_DIE: begin
        if (choice_valid && choice == 2'b00) begin
          ev = 1'b1; ev_tgt = res_game;
        end else if (choice_valid && choice == 2'b01) begin
          ev = 1'b1; ev_tgt = S_MENU;
        end else if (choice_valid && choice == 2'b10 && has_next) begin
          ev = 1'b1; ev_tgt = res_next;
        end else if (timeout) begin
          ev = 1'b1; ev_tgt = S_MENU;
        end
      end
      default: begin
        ev = 1'b1; ev_tgt = S_MENU;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) phase_q <= IDLE;
    else     phase_q <= phase_d;
  end

  always_comb begin
    phase_d = phase_q;
    unique case (1'b1)
      phase_q == IDLE:   if (ev) phase_d = BLANK;
      phase_q == BLANK:  if (frame_tick && cnt_q <= 8'd1) phase_d = SWITCH;
      phase_q == SWITCH: phase_d = IDLE;
      default:           phase_d = IDLE;
    endcase
  end

  assign tgt_ok = (target_q == S_B1_OK) || (target_q == S_B2_OK) ||
                  (target_q == S_SD_OK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scene_q  <= S_MENU;
      target_q <= S_MENU;
      cnt_q    <= '0;
      clear_q  <= '0;
    end else begin
      unique case (phase_q)
        IDLE: begin
          if (ev) begin
            target_q <= ev_tgt;
            cnt_q    <= BF_LOAD;
          end
        end
        BLANK: begin
          if (frame_tick) cnt_q <= cnt_q - 8'd1;
        end
        SWITCH: begin
          scene_q <= target_q;
          if (tgt_ok && clear_q != 8'hff) clear_q <= clear_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Result-screen idle timer; saturates rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tcnt_q <= '0;
    else if (phase_q == SWITCH)
      tcnt_q <= '0;
    else if (phase_q == IDLE && is_res && frame_tick && tcnt_q != 16'hffff)
      tcnt_q <= tcnt_q + 16'd1;
  end

  assign live_game = (scene_q == S_B1) || (scene_q == S_B2) ||
                     (scene_q == S_SD);

  always_comb begin
    blank        = (phase_q != IDLE);
    game_restart = blank || !live_game;
    scene        = scene_q;
    clear_count  = clear_q;
  end

endmodule

// File: tb/tb_scene_sequencer.sv
// Directed testbench for scene_sequencer.
// Each task drives one scenario and checks outputs inline.
module tb_scene_sequencer;

  logic       clk;
  logic       rst;
  logic       frame_tick;
  logic [4:0] key_pulse;
  logic       menu_valid;
  logic [1:0] menu_sel;
  logic       game_done;
  logic       game_die;
  logic       choice_valid;
  logic [1:0] choice;
  logic [3:0] scene;
  logic       blank;
  logic       game_restart;
  logic [7:0] clear_count;

  int passed = 0;
  int total  = 0;

  scene_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .key_pulse    (key_pulse),
    .menu_valid   (menu_valid),
    .menu_sel     (menu_sel),
    .game_done    (game_done),
    .game_die     (game_die),
    .choice_valid (choice_valid),
    .choice       (choice),
    .scene        (scene),
    .blank        (blank),
    .game_restart (game_restart),
    .clear_count  (clear_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  // After an event cycle: 8 ticks of BLANK, then SWITCH.
  task automatic run_blank();
    repeat (8) tick();
    step();
  endtask

  task automatic pick_menu(input logic [1:0] s);
    menu_valid = 1'b1; menu_sel = s;
    step();
    menu_valid = 1'b0; menu_sel = 2'b00;
  endtask

  task automatic pick_choice(input logic [1:0] c);
    choice_valid = 1'b1; choice = c;
    step();
    choice_valid = 1'b0; choice = 2'b00;
  endtask

  task automatic pulse_done();
    game_done = 1'b1;
    step();
    game_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    total++;
    if (scene !== 4'd0 || blank !== 1'b0 || game_restart !== 1'b1 ||
        clear_count !== 8'd0)
      $display("FAIL reset: scene=%0d blank=%0d restart=%0d clr=%0d, want 0 0 1 0",
               scene, blank, game_restart, clear_count);
    else passed++;
    rst = 1'b0;
    step(2);
    total++;
    if (scene !== 4'd0 || blank !== 1'b0)
      $display("FAIL reset_release: scene=%0d blank=%0d, want 0 0", scene, blank);
    else passed++;
  endtask

  task automatic test_menu_to_b1();
    bit bad = 0;
    pick_menu(2'b01);
    for (int i = 0; i < 8; i++) begin
      if (blank !== 1'b1 || scene !== 4'd0) bad = 1;
      tick();
    end
    total++;
    if (bad) $display("FAIL m2b1_blanking: blank dropped or scene moved early");
    else passed++;
    total++;
    if (blank !== 1'b1 || scene !== 4'd0)
      $display("FAIL m2b1_switch: blank=%0d scene=%0d, want 1 0", blank, scene);
    else passed++;
    step();
    total++;
    if (scene !== 4'd1 || blank !== 1'b0 || game_restart !== 1'b0)
      $display("FAIL m2b1_live: scene=%0d blank=%0d restart=%0d, want 1 0 0",
               scene, blank, game_restart);
    else passed++;
  endtask

  task automatic test_done_die();
    game_done = 1'b1; game_die = 1'b1;
    step();
    game_done = 1'b0; game_die = 1'b0;
    run_blank();
    total++;
    if (scene !== 4'd2 || clear_count !== 8'd1)
      $display("FAIL done_wins: scene=%0d clr=%0d, want 2 1", scene, clear_count);
    else passed++;
  endtask

  task automatic test_next();
    pick_choice(2'b10);
    run_blank();
    total++;
    if (scene !== 4'd4)
      $display("FAIL next_b1ok: scene=%0d, want 4", scene);
    else passed++;
    game_die = 1'b1;
    step();
    game_die = 1'b0;
    run_blank();
    total++;
    if (scene !== 4'd6 || clear_count !== 8'd1)
      $display("FAIL b2_die: scene=%0d clr=%0d, want 6 1", scene, clear_count);
    else passed++;
    pick_choice(2'b10);
    repeat (10) tick();
    total++;
    if (scene !== 4'd6 || blank !== 1'b0)
      $display("FAIL die_next_ignored: scene=%0d blank=%0d, want 6 0", scene, blank);
    else passed++;
    pick_choice(2'b11);
    step(2);
    total++;
    if (blank !== 1'b0)
      $display("FAIL choice11_ignored: blank=%0d, want 0", blank);
    else passed++;
    pick_choice(2'b00);
    run_blank();
    total++;
    if (scene !== 4'd4)
      $display("FAIL die_retry: scene=%0d, want 4", scene);
    else passed++;
  endtask

  task automatic test_esc();
    bit bad = 0;
    pulse_done();
    run_blank();
    total++;
    if (scene !== 4'd5 || clear_count !== 8'd2)
      $display("FAIL b2_done: scene=%0d clr=%0d, want 5 2", scene, clear_count);
    else passed++;
    pick_choice(2'b10);
    run_blank();
    total++;
    if (scene !== 4'd7 || game_restart !== 1'b0)
      $display("FAIL next_b2ok: scene=%0d restart=%0d, want 7 0", scene, game_restart);
    else passed++;
    key_pulse = 5'h1b;
    step();
    key_pulse = 5'h00;
    for (int i = 0; i < 8; i++) begin
      if (blank !== 1'b1 || game_restart !== 1'b1 || scene !== 4'd7) bad = 1;
      if (i == 3) key_pulse = 5'h1b;
      tick();
      key_pulse = 5'h00;
    end
    step();
    total++;
    if (bad) $display("FAIL esc_blank: blank/restart not held or scene moved");
    else passed++;
    step(3);
    total++;
    if (scene !== 4'd7 || blank !== 1'b0 || game_restart !== 1'b0)
      $display("FAIL esc_restart: scene=%0d blank=%0d restart=%0d, want 7 0 0",
               scene, blank, game_restart);
    else passed++;
    key_pulse = 5'h1a;
    step(2);
    key_pulse = 5'h00;
    total++;
    if (blank !== 1'b0)
      $display("FAIL other_key: blank=%0d, want 0", blank);
    else passed++;
  endtask

  task automatic test_timeout();
    pulse_done();
    run_blank();
    total++;
    if (scene !== 4'd8 || clear_count !== 8'd3)
      $display("FAIL sd_done: scene=%0d clr=%0d, want 8 3", scene, clear_count);
    else passed++;
    repeat (599) tick();
    total++;
    if (scene !== 4'd8 || blank !== 1'b0)
      $display("FAIL timeout_early: scene=%0d blank=%0d, want 8 0", scene, blank);
    else passed++;
    tick();
    total++;
    if (blank !== 1'b1)
      $display("FAIL timeout_fire: blank=%0d, want 1", blank);
    else passed++;
    run_blank();
    total++;
    if (scene !== 4'd0)
      $display("FAIL timeout_menu: scene=%0d, want 0", scene);
    else passed++;
    pick_menu(2'b00);
    run_blank();
    pulse_done();
    run_blank();
    total++;
    if (scene !== 4'd8 || clear_count !== 8'd4)
      $display("FAIL sd_done2: scene=%0d clr=%0d, want 8 4", scene, clear_count);
    else passed++;
    repeat (599) tick();
    choice_valid = 1'b1; choice = 2'b01;
    tick();
    choice_valid = 1'b0; choice = 2'b00;
    run_blank();
    total++;
    if (scene !== 4'd0 || blank !== 1'b0)
      $display("FAIL choice_vs_timeout: scene=%0d blank=%0d, want 0 0", scene, blank);
    else passed++;
    repeat (3) tick();
    total++;
    if (scene !== 4'd0 || blank !== 1'b0)
      $display("FAIL single_transition: scene=%0d blank=%0d, want 0 0", scene, blank);
    else passed++;
  endtask

  task automatic test_rst_mid_blank();
    pick_menu(2'b01);
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    total++;
    if (scene !== 4'd0 || blank !== 1'b0 || clear_count !== 8'd0)
      $display("FAIL rst_async: scene=%0d blank=%0d clr=%0d, want 0 0 0",
               scene, blank, clear_count);
    else passed++;
    step();
    rst = 1'b0;
    repeat (10) tick();
    total++;
    if (scene !== 4'd0 || blank !== 1'b0)
      $display("FAIL rst_abort: scene=%0d blank=%0d, want 0 0", scene, blank);
    else passed++;
  endtask

  task automatic test_saturate();
    pick_menu(2'b01);
    run_blank();
    for (int i = 1; i <= 260; i++) begin
      pulse_done();
      run_blank();
      if (i == 254) begin
        total++;
        if (clear_count !== 8'd254)
          $display("FAIL clr_254: clr=%0d, want 254", clear_count);
        else passed++;
      end
      if (i == 255) begin
        total++;
        if (clear_count !== 8'd255)
          $display("FAIL clr_255: clr=%0d, want 255", clear_count);
        else passed++;
      end
      pick_choice(2'b00);
      run_blank();
    end
    total++;
    if (clear_count !== 8'd255 || scene !== 4'd1)
      $display("FAIL clr_sat: clr=%0d scene=%0d, want 255 1", clear_count, scene);
    else passed++;
  endtask

  initial begin
    rst = 1'b1;
    frame_tick = 1'b0;
    key_pulse = 5'h00;
    menu_valid = 1'b0;
    menu_sel = 2'b00;
    game_done = 1'b0;
    game_die = 1'b0;
    choice_valid = 1'b0;
    choice = 2'b00;
    test_reset();
    test_menu_to_b1();
    test_done_die();
    test_next();
    test_esc();
    test_timeout();
    test_rst_mid_blank();
    test_saturate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
